// File: rtl/gf2n_power_sbox_seq.sv
// rtl/gf2n_power_sbox_seq.sv - sequential GF(2^N) power-map S-box, y = x^E xor {N{parity(x & MASK)}}
module gf2n_power_sbox_seq #(
   parameter int            N    = 6,
   parameter logic [N:0]    POLY = 7'b1000011,
   parameter logic [N-1:0]  MASK = 6'b010100
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_x,
   input  logic [N-1:0] in_e,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_y,
   output logic         busy
);

   localparam int KW = $clog2(N);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   acc_q, acc_d;
   logic [N-1:0]   base_q, base_d;
   logic [N-1:0]   exp_q, exp_d;
   logic           t_q, t_d;
   logic [KW-1:0]  k_q, k_d;
   logic [N-1:0]   y_q, y_d;
   logic [N-1:0]   sq, prod, step;
   logic           accept;

   // Shift-and-add multiply with the reduction folded into each shift of a,
   // so the operand never grows past N bits.
   function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] p;
      logic [N-1:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < N; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[N-1] ? ((aa << 1) ^ POLY[N-1:0]) : (aa << 1);
      end
      return p;
   endfunction

   assign in_ready  = (state_q == IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign out_y     = y_q;
   assign busy      = (state_q != IDLE);

   // One MSB-first square-and-multiply step, fully combinational.
   always_comb begin
      sq   = gf_mul(acc_q, acc_q);
      prod = gf_mul(sq, base_q);
      step = exp_q[k_q] ? prod : sq;
   end

   // Next-state and datapath updates for IDLE -> RUN (N steps) -> DONE.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      base_d  = base_q;
      exp_d   = exp_q;
      t_d     = t_q;
      k_d     = k_q;
      y_d     = y_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               base_d  = in_x;
               exp_d   = in_e;
               t_d     = ^(in_x & MASK);
               acc_d   = N'(1);
               k_d     = KW'(N - 1);
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = step;
            if (k_q == '0) begin
               y_d     = step ^ {N{t_q}};
               state_d = DONE;
            end else begin
               k_d = k_q - KW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         base_q  <= '0;
         exp_q   <= '0;
         t_q     <= 1'b0;
         k_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         base_q  <= base_d;
         exp_q   <= exp_d;
         t_q     <= t_d;
         k_q     <= k_d;
         y_q     <= y_d;
      end
   end

endmodule

// File: tb/tb_gf2n_power_sbox_seq.sv
// tb/tb_gf2n_power_sbox_seq.sv - self-checking bench for gf2n_power_sbox_seq
module tb_gf2n_power_sbox_seq;

   localparam int         N    = 6;
   localparam logic [6:0] POLY = 7'b1000011;
   localparam logic [5:0] MASK = 6'b010100;
   localparam int         NREQ = 1000;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_x;
   logic [5:0] in_e;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_y;
   logic       busy;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   typedef struct {
      logic [5:0] x;
      logic [5:0] e;
      logic [5:0] y;
   } vec_t;

   typedef struct {
      logic [5:0] y;
      int         acc_cyc;
   } exp_t;

   vec_t vt[7];
   exp_t sb[$];

   gf2n_power_sbox_seq #(.N(N), .POLY(POLY), .MASK(MASK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_e      (in_e),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Full 12-bit polynomial product, then long division by the modulus.
   function automatic logic [5:0] m_mul(input logic [5:0] a, input logic [5:0] b);
      logic [11:0] p;
      p = '0;
      for (int i = 0; i < 6; i++)
         if (b[i]) p = p ^ (12'(a) << i);
      for (int d = 11; d >= 6; d--)
         if (p[d]) p = p ^ (12'(POLY) << (d - 6));
      return p[5:0];
   endfunction

   // x^e by repeated multiplication, then the parity mask of the input.
   function automatic logic [5:0] m_sbox(input logic [5:0] x, input logic [5:0] e);
      logic [5:0] r;
      logic       t;
      r = 6'd1;
      for (int i = 0; i < int'(e); i++) r = m_mul(r, x);
      t = ^(x & MASK);
      return r ^ {6{t}};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, req);
   endtask

   task automatic run_req(input logic [5:0] x, input logic [5:0] e,
                          output logic [5:0] y, output int lat);
      int w;
      in_valid = 1'b1;
      in_x     = x;
      in_e     = e;
      w        = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_x     = 6'($urandom);
      in_e     = 6'($urandom);
      lat      = 1;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      y         = out_y;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [5:0] y;
      int         lat;
      int         w;
      int         vcnt;

      vt[0] = '{x: 6'h02, e: 6'd13, y: 6'h0A};
      vt[1] = '{x: 6'h04, e: 6'd13, y: 6'h38};
      vt[2] = '{x: 6'h01, e: 6'd13, y: 6'h01};
      vt[3] = '{x: 6'h00, e: 6'd13, y: 6'h00};
      vt[4] = '{x: 6'h02, e: 6'd63, y: 6'h01};
      vt[5] = '{x: 6'h00, e: 6'd0,  y: 6'h01};
      vt[6] = '{x: 6'h14, e: 6'd1,  y: 6'h14};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_x      = '0;
      in_e      = '0;
      out_ready = 1'b0;

      // Reset then idle
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_y",     32'(out_y),     0);
      chk("rst_busy",      32'(busy),      0);
      chk("rst_in_ready",  32'(in_ready),  0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);
      @(negedge clk);

      // Directed vectors
      for (int i = 0; i < 7; i++) begin
         run_req(vt[i].x, vt[i].e, y, lat);
         chk($sformatf("vec%0d_y", i),   32'(y),   32'(vt[i].y));
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(N + 1));
      end

      // Backpressure with a second request waiting during DONE
      in_valid = 1'b1;
      in_x     = 6'h02;
      in_e     = 6'd13;
      w        = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      @(negedge clk);
      in_valid = 1'b0;
      w        = 0;
      while (!out_valid && w < 50) begin @(negedge clk); w++; end
      in_valid = 1'b1;
      in_x     = 6'h04;
      in_e     = 6'd13;
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_out_y",     32'(out_y),     32'h0A);
         chk("bp_in_ready",  32'(in_ready),  0);
         chk("bp_busy",      32'(busy),      1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drain_out_valid", 32'(out_valid), 0);
      chk("drain_in_ready",  32'(in_ready),  1);
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
      chk("second_y",   32'(out_y), 32'h38);
      chk("second_lat", 32'(lat),   32'(N + 1));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Mid-operation reset
      in_valid = 1'b1;
      in_x     = 6'h02;
      in_e     = 6'd13;
      w        = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      vcnt = 0;
      out_ready = 1'b1;
      for (int i = 0; i < N + 6; i++) begin
         if (out_valid) vcnt++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("midrst_no_result", 32'(vcnt), 0);
      run_req(6'h04, 6'd13, y, lat);
      chk("midrst_fresh_y",   32'(y),   32'h38);
      chk("midrst_fresh_lat", 32'(lat), 32'(N + 1));

      // Randomised traffic against the model
      @(negedge clk);
      fork
         begin : producer
            for (int i = 0; i < NREQ; i++) begin
               logic [5:0] rx, re;
               int         pw;
               exp_t       ent;
               repeat ($urandom_range(0, 2)) @(negedge clk);
               rx       = 6'($urandom);
               re       = 6'($urandom);
               in_valid = 1'b1;
               in_x     = rx;
               in_e     = re;
               pw       = 0;
               while (!in_ready && pw < 200) begin @(negedge clk); pw++; end
               if (!in_ready) chk("rand_accept_timeout", 0, 1);
               ent.y       = m_sbox(rx, re);
               ent.acc_cyc = cyc;
               sb.push_back(ent);
               @(negedge clk);
               in_valid = 1'b0;
               in_x     = 6'($urandom);
               in_e     = 6'($urandom);
            end
         end
         begin : consumer
            int   got;
            int   guard;
            int   rise;
            logic prev_v;
            exp_t ent;
            got    = 0;
            guard  = 0;
            rise   = 0;
            prev_v = 1'b0;
            while (got < NREQ && guard < 60000) begin
               @(negedge clk);
               guard++;
               out_ready = 1'($urandom_range(0, 1));
               if (out_valid && !prev_v) rise = cyc;
               if (out_valid && out_ready) begin
                  if (sb.size() == 0) begin
                     chk("rand_unexpected_result", 1, 0);
                  end else begin
                     ent = sb.pop_front();
                     chk("rand_y",   32'(out_y),              32'(ent.y));
                     chk("rand_lat", 32'(rise - ent.acc_cyc), 32'(N + 1));
                  end
                  got++;
               end
               prev_v = out_valid;
            end
            @(negedge clk);
            out_ready = 1'b0;
            chk("rand_count", 32'(got), 32'(NREQ));
         end
      join
      chk("rand_sb_empty", 32'(sb.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
